// File: rtl/v810_bus_arb.sv
// v810_bus_arb: single-transaction arbiter placing EU fetch (I) and data (D) requests on one bus-cycle port (B).
// Define V810_ARB_STARVE_LIMIT_EN to bound how many D grants may pass a waiting fetch.
module v810_bus_arb #(
    parameter logic [1:0] IFETCH_ST  = 2'b10,
    parameter int         STARVE_MAX = 4,
    parameter int         CNT_W      = 3
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] IA,
    input  logic        IREQ,
    output logic [31:0] ID,
    output logic        IACK,
    input  logic [31:0] DA,
    input  logic [31:0] DD_O,
    output logic [31:0] DD_I,
    input  logic [3:0]  DBE,
    input  logic        DWR,
    input  logic        DMRQ,
    input  logic [1:0]  DST,
    input  logic        DREQ,
    output logic        DACK,
    output logic [31:0] BA,
    output logic [31:0] BDO,
    input  logic [31:0] BDI,
    output logic [3:0]  BBE,
    output logic        BWR,
    output logic        BMRQ,
    output logic [1:0]  BST,
    output logic        BREQ,
    input  logic        BACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        mrq;
        logic [1:0]  st;
    } bus_req_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state, state_nx;
    bus_req_t         req_d, req_i, req_win, bus_q;
    logic             win_d_q;
    logic             breq_q, iack_q, dack_q;
    logic [31:0]      id_q, ddi_q;
    logic             grant_d, grant_i, bus_done;
    logic             starve_hit;
    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        req_d.addr  = DA;
        req_d.wdata = DD_O;
        req_d.be    = DBE;
        req_d.wr    = DWR;
        req_d.mrq   = DMRQ;
        req_d.st    = DST;

        req_i.addr  = IA;
        req_i.wdata = 32'h0;
        req_i.be    = 4'hF;
        req_i.wr    = 1'b0;
        req_i.mrq   = 1'b1;
        req_i.st    = IFETCH_ST;

        req_win = grant_d ? req_d : req_i;
    end

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        bus_done = 1'b0;
        case (state)
            IDLE: begin
                // D normally wins; a saturated starvation count hands the slot to I
                if (DREQ && !starve_hit) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY;
                end else if (IREQ) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (BACK) begin
                    bus_done = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state   <= IDLE;
            bus_q   <= '0;
            win_d_q <= 1'b0;
            breq_q  <= 1'b0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
            id_q    <= 32'h0;
            ddi_q   <= 32'h0;
        end else if (CE) begin
            state  <= state_nx;
            iack_q <= 1'b0;
            dack_q <= 1'b0;
            if (grant_d || grant_i) begin
                bus_q   <= req_win;
                win_d_q <= grant_d;
                breq_q  <= 1'b1;
            end
            // ACK is registered so it is high exactly while in DONE
            if (bus_done) begin
                breq_q <= 1'b0;
                if (win_d_q) begin
                    dack_q <= 1'b1;
                    if (!bus_q.wr) ddi_q <= BDI;
                end else begin
                    iack_q <= 1'b1;
                    id_q   <= BDI;
                end
            end
        end
    end

`ifdef V810_ARB_STARVE_LIMIT_EN
    localparam bit STARVE_EN = 1'b1;

    // Counts D grants that overtook a pending fetch; saturates at the limit
    always_ff @(posedge CLK) begin
        if (RES) begin
            starve_cnt <= '0;
        end else if (CE && state == IDLE) begin
            if (!IREQ || grant_i)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    localparam bit STARVE_EN = 1'b0;

    assign starve_cnt = '0;
`endif

    assign starve_hit = STARVE_EN && IREQ && (starve_cnt == STARVE_LIM);

    assign BA   = bus_q.addr;
    assign BDO  = bus_q.wdata;
    assign BBE  = bus_q.be;
    assign BWR  = bus_q.wr;
    assign BMRQ = bus_q.mrq;
    assign BST  = bus_q.st;
    assign BREQ = breq_q;
    assign IACK = iack_q;
    assign DACK = dack_q;
    assign ID   = id_q;
    assign DD_I = ddi_q;

endmodule
